// File: rtl/fcp_pkg.sv
// rtl/fcp_pkg.sv - shared state encoding and bus constants for the FCP slave
package fcp_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        HDR_ACK,
        RX_DATA,
        RX_ACK,
        TX_TURN,
        TX_DATA,
        TX_ACK,
        WAIT_STOP,
        DONE
    } fcp_state_t;

    localparam logic [1:0] CTRL_START = 2'b01;
    localparam logic [1:0] CTRL_SLAVE = 2'b10;
    localparam logic [1:0] CTRL_STOP  = 2'b11;
    localparam logic       ACK        = 1'b0;
    localparam logic       NACK       = 1'b1;

endpackage

// File: rtl/fcp_slave_multi_if.sv
// rtl/fcp_slave_multi_if.sv - local register-load and receive-report side of the slave
interface fcp_slave_multi_if #(
    parameter int DEPTH = 4
);
    localparam int IW = $clog2(DEPTH);

    logic          load_en;
    logic [IW-1:0] load_idx;
    logic [7:0]    load_data;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic [IW-1:0] rx_index;
    logic          busy;
    logic          err;

    modport slave (
        input  load_en, load_idx, load_data,
        output rx_valid, rx_byte, rx_index, busy, err
    );

    modport master (
        output load_en, load_idx, load_data,
        input  rx_valid, rx_byte, rx_index, busy, err
    );

endinterface

// File: rtl/fcp_lane_shift.sv
// rtl/fcp_lane_shift.sv - MSB-first beat deserialiser and serialiser for LANES-wide data
module fcp_lane_shift #(
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [LANES-1:0] din,
    input  logic [7:0]       tx_byte,
    input  logic [3:0]       beat,
    output logic [7:0]       rx_next,
    output logic [LANES-1:0] dout
);

    logic [7:0] sh;

    // rx_next already includes the beat on the bus, so the last beat can be consumed the same cycle
    assign rx_next = 8'({sh, din});
    assign dout    = LANES'(tx_byte >> (8 - LANES * (int'(beat) + 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else if (shift_en) begin
            sh <= rx_next;
        end
    end

endmodule

// File: rtl/fcp_slave_multi.sv
// rtl/fcp_slave_multi.sv - multi-lane framed bus slave with register file, read retry and abort
module fcp_slave_multi
    import fcp_pkg::*;
#(
    parameter int         LANES     = 2,
    parameter logic [6:0] SLV_ADDR  = 7'h2A,
    parameter int         DEPTH     = 4,
    parameter int         MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [1:0]       ctrl,
    inout  wire  [LANES-1:0] data,
    inout  wire              ack,
    fcp_slave_multi_if.slave host
);

    localparam int         IW   = $clog2(DEPTH);
    localparam int         BPB  = 8 / LANES;
    localparam int         RW   = $clog2(MAX_RETRY + 1);
    localparam logic [3:0] LAST = 4'(BPB - 1);

    fcp_state_t       state, state_n;
    logic [3:0]       beat;
    logic [IW-1:0]    idx;
    logic [RW-1:0]    retry;
    logic             rw;
    logic [7:0]       regs [DEPTH];
    logic             rx_valid, err;
    logic [7:0]       rx_byte;
    logic [IW-1:0]    rx_index;
    logic             ctrl_en, data_en, ack_en;
    logic [LANES-1:0] data_out, tx_beat;
    logic [7:0]       rx_next;
    logic             start, stop, ack_ok, last, hit, retry_last, wr_bus, give_up;

    fcp_lane_shift #(.LANES(LANES)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en ((state == HDR) || (state == RX_DATA)),
        .din      (data),
        .tx_byte  (regs[idx]),
        .beat     (beat),
        .rx_next  (rx_next),
        .dout     (tx_beat)
    );

    // Undriven or unknown bus values decode as "not START / not STOP / NACK"
    always_comb begin
        start  = 1'b0;
        stop   = 1'b0;
        ack_ok = 1'b0;
        if (ctrl == CTRL_START) start = 1'b1;
        if (ctrl == CTRL_STOP)  stop  = 1'b1;
        if (ack == ACK)         ack_ok = 1'b1;
    end

    assign last       = (beat == LAST);
    assign hit        = (rx_next[7:1] == SLV_ADDR);
    assign retry_last = (retry == RW'(MAX_RETRY - 1));
    assign wr_bus     = (state == RX_DATA) && last && !stop;
    assign give_up    = (state == TX_ACK) && !stop && !ack_ok && retry_last;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (start) state_n = HDR;
            HDR:       if (last) state_n = hit ? HDR_ACK : WAIT_STOP;
            HDR_ACK:   state_n = rw ? RX_DATA : TX_TURN;
            RX_DATA:   if (last) state_n = RX_ACK;
            RX_ACK:    state_n = RX_DATA;
            TX_TURN:   state_n = TX_DATA;
            TX_DATA:   if (last) state_n = TX_ACK;
            TX_ACK:    state_n = (ack_ok || !retry_last) ? TX_TURN : WAIT_STOP;
            WAIT_STOP: state_n = WAIT_STOP;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        // While the slave owns ctrl its own 10 must not be mistaken for STOP
        if (stop && state != IDLE && state != TX_DATA && state != DONE) state_n = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= '0;
            idx      <= '0;
            retry    <= '0;
            rw       <= 1'b0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            rx_index <= '0;
            err      <= 1'b0;
        end else begin
            rx_valid <= wr_bus;
            err      <= give_up;
            if (state == HDR || state == RX_DATA || state == TX_DATA) beat <= last ? 4'd0 : beat + 4'd1;
            else                                                      beat <= '0;
            if (state == HDR && last) rw <= rx_next[0];
            if (wr_bus) begin
                rx_byte  <= rx_next;
                rx_index <= idx;
            end
            case (state)
                IDLE: begin
                    idx   <= '0;
                    retry <= '0;
                end
                RX_ACK: if (!stop) idx <= idx + 1'b1;
                TX_ACK: if (!stop) begin
                    if (ack_ok) begin
                        idx   <= idx + 1'b1;
                        retry <= '0;
                    end else begin
                        retry <= retry + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus write is ordered after the local load so it wins on an index collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (host.load_en) regs[host.load_idx] <= host.load_data;
            if (wr_bus)       regs[idx]           <= rx_next;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            ctrl_en <= 1'b0;
            data_en <= 1'b0;
            ack_en  <= 1'b0;
        end else begin
            ctrl_en <= (state == TX_DATA);
            data_en <= (state == TX_DATA);
            ack_en  <= (state == HDR_ACK) || (state == RX_ACK);
        end
        data_out <= tx_beat;
    end

    assign ctrl = ctrl_en ? CTRL_SLAVE : 2'bzz;
    assign data = data_en ? data_out : {LANES{1'bz}};
    assign ack  = ack_en  ? ACK : 1'bz;

    assign host.rx_valid = rx_valid;
    assign host.rx_byte  = rx_byte;
    assign host.rx_index = rx_index;
    assign host.busy     = (state != IDLE);
    assign host.err      = err;

endmodule
